// File: rtl/dt24_rx_bridge.sv
// DT24 pad receiver: synchronises an asynchronous strobe/we/data pad bus into wb_clk_i,
// buffers captured words in a FWFT FIFO and frames them as a pixel stream. Optional macro: DT24_ERR_CNT_EN.
module dt24_rx_bridge #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_n_i,
  input  logic                            dt24_clk_i,
  input  logic                            dt24_we_i,
  input  logic [DATA_WIDTH-1:0]           dt24_data_i,
  output logic                            dt24_clk_oenb,
  output logic                            dt24_we_oenb,
  output logic [DATA_WIDTH-1:0]           dt24_data_oenb,
  input  logic                            enable_i,
  input  logic [18:0]                     frame_len_i,
  output logic                            pix_valid_o,
  output logic [DATA_WIDTH-1:0]           pix_data_o,
  input  logic                            pix_ready_i,
  output logic                            pix_last_o,
  output logic                            frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            ovf_o,
  input  logic                            ovf_clr_i
`ifdef DT24_ERR_CNT_EN
  ,
  output logic [15:0]                     err_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Pads are permanently inputs.
  assign dt24_clk_oenb  = 1'b1;
  assign dt24_we_oenb   = 1'b1;
  assign dt24_data_oenb = '1;

  logic                  strb_s1, strb_s2, strb_h;
  logic                  we_s1, we_s2;
  logic [DATA_WIDTH-1:0] data_s1, data_s2;
  logic [1:0]            primed_q;
  logic                  armed_q;

  // primed_q marks when strb_s2 holds a real pad sample rather than its reset value,
  // so a strobe held high through reset cannot arm the detector.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      strb_s1  <= 1'b0;
      strb_s2  <= 1'b0;
      strb_h   <= 1'b0;
      we_s1    <= 1'b0;
      we_s2    <= 1'b0;
      data_s1  <= '0;
      data_s2  <= '0;
      primed_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      strb_s1  <= dt24_clk_i;
      strb_s2  <= strb_s1;
      strb_h   <= strb_s2;
      we_s1    <= dt24_we_i;
      we_s2    <= we_s1;
      data_s1  <= dt24_data_i;
      data_s2  <= data_s1;
      primed_q <= {primed_q[0], 1'b1};
      if (primed_q[1] && !strb_s2) armed_q <= 1'b1;
    end
  end

  logic capture;
  assign capture = strb_s2 && !strb_h && we_s2 && enable_i && armed_q;

  // FIFO with one extra pointer bit to tell full from empty.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level;
  logic                  empty, full, pop, push_ok, drop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = !empty && pix_ready_i;
  assign push_ok = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_o    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)           ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by the pointers and the output is gated.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= data_s2;
  end

  assign pix_valid_o  = !empty;
  assign pix_data_o   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign fifo_level_o = level;

`ifdef DT24_ERR_CNT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      err_cnt_o <= '0;
    end else if (drop) begin
      if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end else if (ovf_clr_i) begin
      err_cnt_o <= '0;
    end
  end
`endif

  // Frame position counter.
  state_t      state_q, state_d;
  logic [18:0] count_q, count_d;
  logic        done_q, done_d;
  logic        is_last;

  assign is_last    = (frame_len_i != '0) && (count_q == frame_len_i - 19'd1);
  assign pix_last_o = pix_valid_o && is_last;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (frame_len_i == '0) begin
      state_d = IDLE;
      count_d = '0;
    end else if (pop && is_last) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b1;
    end else if (!enable_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (pop) begin
      state_d = ACTIVE;
      count_d = count_q + 19'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign frame_done_o = done_q;

endmodule
